sample_fifo_sequencer: RTL and testbench

Hardware read sequencer between the audio sample dual-clock FIFO (read side) and the Nios II PIO ports of `nios2_subsystem`. It prefetches one sample from the FIFO, holds it for software, and releases it on a software-toggled request edge, so firmware never drives the FIFO read strobe directly. It also tracks FIFO overflow. It forwards values software writes to the data-back PIO to the downstream visualizer over a valid/ready link.

---
 rtl/sample_fifo_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sample_fifo_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo_sequencer.sv
// ============================================================================
// sample_fifo_sequencer: prefetches one FIFO sample for Nios PIO software,
// tracks FIFO overflow and forwards data-back words over valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_fifo_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [DATA_WIDTH-1:0]    fifo_q,
    input  logic                     fifo_rdempty,
    input  logic                     fifo_rdfull,
    output logic                     fifo_rdreq,
    input  logic                     cpu_rdreq,
    output logic [DATA_WIDTH-1:0]    cpu_q,
    output logic                     cpu_empty,
    output logic                     cpu_full,
    input  logic [DATA_WIDTH-1:0]    cpu_data_back,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_LATCH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [OVF_CNT_WIDTH-1:0] C_OVF_ONE = OVF_CNT_WIDTH'(1);
    localparam logic [OVF_CNT_WIDTH-1:0] C_OVF_MAX = '1;

    state_t                   state_q;
    logic                     fifo_rdreq_q;
    logic [DATA_WIDTH-1:0]    cpu_q_q;
    logic                     cpu_empty_q;

    logic                     rdreq_dly_q;
    logic                     full_dly_q;
    logic                     cpu_full_q;
    logic                     cpu_full_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_d;

    logic [DATA_WIDTH-1:0]    last_back_q;
    logic [DATA_WIDTH-1:0]    last_back_d;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic [DATA_WIDTH-1:0]    out_data_d;
    logic                     out_valid_q;
    logic                     out_valid_d;

    logic                     w_consume;
    logic                     w_full_rise;
    logic                     w_back_change;

    assign w_consume     = cpu_rdreq && !rdreq_dly_q;
    assign w_full_rise   = fifo_rdfull && !full_dly_q;
    assign w_back_change = (cpu_data_back != last_back_q);

    // Read sequencer: the FIFO is popped only from IDLE, so each held
    // sample costs exactly one pop and edges outside HOLD are dropped.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            fifo_rdreq_q <= 1'b0;
            cpu_q_q      <= '0;
            cpu_empty_q  <= 1'b1;
        end else begin
            fifo_rdreq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_rdempty) begin
                        state_q      <= S_REQ;
                        fifo_rdreq_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    cpu_q_q     <= fifo_q;
                    cpu_empty_q <= 1'b0;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_consume) begin
                        cpu_empty_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (w_full_rise && (ovf_cnt_q != C_OVF_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + C_OVF_ONE;
        end
        cpu_full_d = cpu_full_q;
        if (fifo_rdfull) begin
            cpu_full_d = 1'b1;
        end else if (w_consume) begin
            cpu_full_d = 1'b0;
        end
    end

    // A fresh data-back word always wins over a pending handshake clear.
    always_comb begin
        last_back_d = last_back_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (w_back_change) begin
            last_back_d = cpu_data_back;
            out_data_d  = cpu_data_back;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rdreq_dly_q <= 1'b0;
            full_dly_q  <= 1'b0;
            cpu_full_q  <= 1'b0;
            ovf_cnt_q   <= '0;
            last_back_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rdreq_dly_q <= cpu_rdreq;
            full_dly_q  <= fifo_rdfull;
            cpu_full_q  <= cpu_full_d;
            ovf_cnt_q   <= ovf_cnt_d;
            last_back_q <= last_back_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign fifo_rdreq = fifo_rdreq_q;
    assign cpu_q      = cpu_q_q;
    assign cpu_empty  = cpu_empty_q;
    assign cpu_full   = cpu_full_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign ovf_count  = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_fifo_sequencer.sv
// Directed testbench for sample_fifo_sequencer with a small behavioural FIFO.
`default_nettype none

module tb_sample_fifo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_q = '0;
    logic        fifo_rdempty;
    logic        fifo_rdfull = 1'b0;
    logic        fifo_rdreq;
    logic        cpu_rdreq = 1'b0;
    logic [31:0] cpu_q;
    logic        cpu_empty;
    logic        cpu_full;
    logic [31:0] cpu_data_back = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] ovf_count;

    logic        s_rdreq;
    logic [31:0] s_cpu_q;
    logic        s_empty;
    logic        s_full;
    logic [31:0] s_out_data;
    logic        s_out_valid;
    logic [1:0]  s_ovf;

    logic [31:0] mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pops = 0;
    int          xfers = 0;
    logic [31:0] last_xfer = '0;
    int          total = 0;
    int          bad = 0;
    int          base;

    always #5 clk = ~clk;

    sample_fifo_sequencer #(.DATA_WIDTH(32), .OVF_CNT_WIDTH(16)) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .fifo_q(fifo_q),
        .fifo_rdempty(fifo_rdempty), .fifo_rdfull(fifo_rdfull), .fifo_rdreq(fifo_rdreq),
        .cpu_rdreq(cpu_rdreq), .cpu_q(cpu_q), .cpu_empty(cpu_empty), .cpu_full(cpu_full),
        .cpu_data_back(cpu_data_back), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ovf_count(ovf_count)
    );

    sample_fifo_sequencer #(.DATA_WIDTH(32), .OVF_CNT_WIDTH(2)) u_dut_small (
        .clk_clk(clk), .reset_reset_n(rst_n), .fifo_q(fifo_q),
        .fifo_rdempty(fifo_rdempty), .fifo_rdfull(fifo_rdfull), .fifo_rdreq(s_rdreq),
        .cpu_rdreq(cpu_rdreq), .cpu_q(s_cpu_q), .cpu_empty(s_empty), .cpu_full(s_full),
        .cpu_data_back(cpu_data_back), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .ovf_count(s_ovf)
    );

    // Normal-mode FIFO: data appears the cycle after the read strobe.
    assign fifo_rdempty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rdreq) begin
            fifo_q <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (rst_n && out_valid && out_ready) begin
            xfers     <= xfers + 1;
            last_xfer <= out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr % 16] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push(32'h0000_0011);
        tick();
        tick();
        total++; if (fifo_rdreq !== 1'b0) begin bad++; $display("FAIL rst_rdreq: got %0h want 0", fifo_rdreq); end
        total++; if (cpu_q !== 32'h0) begin bad++; $display("FAIL rst_cpu_q: got %0h want 0", cpu_q); end
        total++; if (cpu_empty !== 1'b1 || cpu_full !== 1'b0) begin bad++; $display("FAIL rst_flags: got empty=%0h full=%0h want 1/0", cpu_empty, cpu_full); end
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || ovf_count !== 16'h0) begin bad++; $display("FAIL rst_out: got v=%0h d=%0h ovf=%0h want 0/0/0", out_valid, out_data, ovf_count); end
        base = pops;
        rst_n = 1'b1;
        tick();
        total++; if (fifo_rdreq !== 1'b1) begin bad++; $display("FAIL pf_rdreq_hi: got %0h want 1", fifo_rdreq); end
        tick();
        total++; if (fifo_rdreq !== 1'b0 || cpu_empty !== 1'b1) begin bad++; $display("FAIL pf_mid: got rdreq=%0h empty=%0h want 0/1", fifo_rdreq, cpu_empty); end
        tick();
        total++; if (cpu_q !== 32'h11 || cpu_empty !== 1'b0) begin bad++; $display("FAIL pf_latch: got q=%0h empty=%0h want 11/0", cpu_q, cpu_empty); end
        repeat (4) tick();
        total++; if (pops - base !== 1 || cpu_q !== 32'h11) begin bad++; $display("FAIL pf_once: got pops=%0d q=%0h want 1/11", pops - base, cpu_q); end
    endtask

    task automatic test_consume();
        base = pops;
        push(32'hA);
        push(32'hB);
        cpu_rdreq = 1'b1;
        tick();
        total++; if (cpu_empty !== 1'b1) begin bad++; $display("FAIL cons_release: got empty=%0h want 1", cpu_empty); end
        repeat (3) tick();
        total++; if (cpu_q !== 32'hA || cpu_empty !== 1'b0) begin bad++; $display("FAIL cons_first: got q=%0h empty=%0h want a/0", cpu_q, cpu_empty); end
        repeat (4) tick();
        total++; if (cpu_q !== 32'hA || cpu_empty !== 1'b0) begin bad++; $display("FAIL cons_held_high: got q=%0h empty=%0h want a/0", cpu_q, cpu_empty); end
        cpu_rdreq = 1'b0; tick();
        cpu_rdreq = 1'b1; tick();
        total++; if (cpu_empty !== 1'b1) begin bad++; $display("FAIL cons_second_rel: got empty=%0h want 1", cpu_empty); end
        repeat (3) tick();
        total++; if (cpu_q !== 32'hB || cpu_empty !== 1'b0) begin bad++; $display("FAIL cons_second: got q=%0h empty=%0h want b/0", cpu_q, cpu_empty); end
        cpu_rdreq = 1'b0; tick();
        cpu_rdreq = 1'b1; tick();
        repeat (5) tick();
        total++; if (cpu_empty !== 1'b1 || fifo_rdempty !== 1'b1 || cpu_q !== 32'hB) begin bad++; $display("FAIL cons_drained: got empty=%0h rdempty=%0h q=%0h want 1/1/b", cpu_empty, fifo_rdempty, cpu_q); end
        total++; if (pops - base !== 2) begin bad++; $display("FAIL cons_pops: got %0d want 2", pops - base); end
        cpu_rdreq = 1'b0;
        tick();
    endtask

    task automatic test_ignore_in_req();
        push(32'hC);
        tick();
        total++; if (fifo_rdreq !== 1'b1) begin bad++; $display("FAIL req_enter: got rdreq=%0h want 1", fifo_rdreq); end
        cpu_rdreq = 1'b1;
        repeat (3) tick();
        total++; if (cpu_q !== 32'hC || cpu_empty !== 1'b0) begin bad++; $display("FAIL req_ignored: got q=%0h empty=%0h want c/0", cpu_q, cpu_empty); end
        repeat (2) tick();
        total++; if (cpu_empty !== 1'b0) begin bad++; $display("FAIL req_not_queued: got empty=%0h want 0", cpu_empty); end
        cpu_rdreq = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            fifo_rdfull = 1'b1;
            repeat (i + 1) tick();
            if (i == 0) begin
                total++; if (cpu_full !== 1'b1 || ovf_count !== 16'd1) begin bad++; $display("FAIL ovf_first: got full=%0h cnt=%0d want 1/1", cpu_full, ovf_count); end
            end
            fifo_rdfull = 1'b0;
            tick();
        end
        total++; if (ovf_count !== 16'd3 || cpu_full !== 1'b1) begin bad++; $display("FAIL ovf_three: got cnt=%0d full=%0h want 3/1", ovf_count, cpu_full); end
        total++; if (s_ovf !== 2'd3) begin bad++; $display("FAIL ovf_small3: got %0d want 3", s_ovf); end
        for (int i = 0; i < 2; i++) begin
            fifo_rdfull = 1'b1; tick();
            fifo_rdfull = 1'b0; tick();
        end
        total++; if (ovf_count !== 16'd5) begin bad++; $display("FAIL ovf_five: got %0d want 5", ovf_count); end
        total++; if (s_ovf !== 2'd3) begin bad++; $display("FAIL ovf_saturate: got %0d want 3", s_ovf); end
        cpu_rdreq = 1'b1;
        tick();
        total++; if (cpu_full !== 1'b0 || cpu_empty !== 1'b1) begin bad++; $display("FAIL ovf_clear: got full=%0h empty=%0h want 0/1", cpu_full, cpu_empty); end
        cpu_rdreq = 1'b0;
        tick();
        push(32'hD);
        repeat (3) tick();
        total++; if (cpu_q !== 32'hD || cpu_empty !== 1'b0) begin bad++; $display("FAIL ovf_refill: got q=%0h empty=%0h want d/0", cpu_q, cpu_empty); end
        fifo_rdfull = 1'b1;
        cpu_rdreq = 1'b1;
        tick();
        total++; if (cpu_full !== 1'b1 || cpu_empty !== 1'b1 || ovf_count !== 16'd6) begin bad++; $display("FAIL ovf_set_wins: got full=%0h empty=%0h cnt=%0d want 1/1/6", cpu_full, cpu_empty, ovf_count); end
        fifo_rdfull = 1'b0;
        cpu_rdreq = 1'b0;
        tick();
    endtask

    task automatic test_data_back();
        base = xfers;
        out_ready = 1'b0;
        cpu_data_back = 32'h5;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin bad++; $display("FAIL db_first: got v=%0h d=%0h want 1/5", out_valid, out_data); end
        cpu_data_back = 32'h7;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h7) begin bad++; $display("FAIL db_overwrite: got v=%0h d=%0h want 1/7", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || xfers - base !== 1 || last_xfer !== 32'h7) begin bad++; $display("FAIL db_xfer: got v=%0h n=%0d d=%0h want 0/1/7", out_valid, xfers - base, last_xfer); end
        repeat (3) tick();
        total++; if (out_valid !== 1'b0 || xfers - base !== 1) begin bad++; $display("FAIL db_same_value: got v=%0h n=%0d want 0/1", out_valid, xfers - base); end
        out_ready = 1'b0;
        cpu_data_back = 32'h9;
        tick();
        out_ready = 1'b1;
        cpu_data_back = 32'hA;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hA || xfers - base !== 2 || last_xfer !== 32'h9) begin bad++; $display("FAIL db_reload: got v=%0h d=%0h n=%0d last=%0h want 1/a/2/9", out_valid, out_data, xfers - base, last_xfer); end
        tick();
        total++; if (out_valid !== 1'b0 || xfers - base !== 3 || last_xfer !== 32'hA) begin bad++; $display("FAIL db_drain: got v=%0h n=%0d last=%0h want 0/3/a", out_valid, xfers - base, last_xfer); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        push(32'hE);
        repeat (3) tick();
        total++; if (cpu_q !== 32'hE || cpu_empty !== 1'b0) begin bad++; $display("FAIL rh_held: got q=%0h empty=%0h want e/0", cpu_q, cpu_empty); end
        rst_n = 1'b0;
        tick();
        total++; if (cpu_q !== 32'h0 || cpu_empty !== 1'b1 || cpu_full !== 1'b0 || fifo_rdreq !== 1'b0) begin bad++; $display("FAIL rh_cpu: got q=%0h empty=%0h full=%0h rdreq=%0h want 0/1/0/0", cpu_q, cpu_empty, cpu_full, fifo_rdreq); end
        total++; if (out_data !== 32'h0 || out_valid !== 1'b0 || ovf_count !== 16'h0) begin bad++; $display("FAIL rh_out: got d=%0h v=%0h cnt=%0d want 0/0/0", out_data, out_valid, ovf_count); end
        push(32'hF);
        cpu_data_back = 32'h0;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (fifo_rdreq !== 1'b1) begin bad++; $display("FAIL rh_restart: got rdreq=%0h want 1", fifo_rdreq); end
        repeat (2) tick();
        total++; if (cpu_q !== 32'hF || cpu_empty !== 1'b0) begin bad++; $display("FAIL rh_refetch: got q=%0h empty=%0h want f/0", cpu_q, cpu_empty); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_consume();
        test_ignore_in_req();
        test_overflow();
        test_data_back();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
